ame_num_divide: RTL and testbench

Sequential unsigned radix-2 restoring divider for the affine motion estimation (AME) path. It sits directly upstream of `ame_num_compare`. It turns each candidate's accumulated cost and sample count into a normalized cost, and those quotients are packed into the comparator's candidate inputs. It handles one division at a time with an init/done handshake, one quotient bit per clock.

---
 rtl/ame_num_divide.sv | 97 +++++++++
 tb/tb_ame_num_divide.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_num_divide.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock.
// Handshake: div_init_i loads operands, div_done_o pulses once when results are valid.
module ame_num_divide #(
  parameter int unsigned DIV_DATA_BITS = 64,
  parameter int unsigned DIV_CNT_BITS  = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     div_init_i,
  output logic                     div_busy_o,
  output logic                     div_done_o,
  input  logic [DIV_DATA_BITS-1:0] div_dividend_i,
  input  logic [DIV_DATA_BITS-1:0] div_divisor_i,
  output logic [DIV_DATA_BITS-1:0] div_quotient_o,
  output logic [DIV_DATA_BITS-1:0] div_remainder_o,
  output logic                     div_zero_o
);

  localparam int unsigned W = DIV_DATA_BITS;
  localparam logic [DIV_CNT_BITS-1:0] LAST_CNT = DIV_CNT_BITS'(DIV_DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state_q, state_d;
  logic [W:0]              rem_q, rem_next;
  logic [W+1:0]            rem_shift;
  logic [W-1:0]            quot_q, quot_next, dvsr_q;
  logic [DIV_CNT_BITS-1:0] cnt_q;
  logic                    zero_q;
  logic                    trial_ok, load, last_step;
  logic [W-1:0]            quot_res_q, rem_res_q;
  logic                    zero_res_q;

  always_comb begin
    load      = ((state_q == IDLE) || (state_q == DONE)) && div_init_i;
    last_step = (state_q == CALC) && (cnt_q == LAST_CNT);
  end

  // Widened compare replaces the sign test of (rem_shifted - D); a zero divisor
  // always passes it, which naturally yields an all-ones quotient and remainder = N.
  always_comb begin
    rem_shift = {rem_q, quot_q[W-1]};
    trial_ok  = (rem_shift >= {2'b00, dvsr_q});
    rem_next  = trial_ok ? (rem_shift[W:0] - {1'b0, dvsr_q}) : rem_shift[W:0];
    quot_next = {quot_q[W-2:0], trial_ok};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_init_i) state_d = CALC;
      CALC:    if (last_step)  state_d = DONE;
      DONE:    state_d = div_init_i ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      quot_res_q <= '0;
      rem_res_q  <= '0;
      zero_res_q <= 1'b0;
    end else if (load) begin
      rem_q  <= '0;
      quot_q <= div_dividend_i;
      dvsr_q <= div_divisor_i;
      cnt_q  <= '0;
      zero_q <= (div_divisor_i == '0);
    end else if (state_q == CALC) begin
      rem_q  <= rem_next;
      quot_q <= quot_next;
      cnt_q  <= cnt_q + DIV_CNT_BITS'(1);
      if (last_step) begin
        quot_res_q <= quot_next;
        rem_res_q  <= rem_next[W-1:0];
        zero_res_q <= zero_q;
      end
    end
  end

  assign div_busy_o      = (state_q == CALC);
  assign div_done_o      = (state_q == DONE);
  assign div_quotient_o  = quot_res_q;
  assign div_remainder_o = rem_res_q;
  assign div_zero_o      = zero_res_q;

endmodule

// File: tb/tb_ame_num_divide.sv
// Scoreboard bench for ame_num_divide: expected results queued at load, checked at each done pulse.
module tb_ame_num_divide;

  localparam int W = 64;

  logic         clk, rst_n, init;
  logic         busy, done, zero;
  logic [W-1:0] dvd, dvs, quot, rem;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] hq = '0, hr = '0;
  logic         hz = 1'b0;

  ame_num_divide #(.DIV_DATA_BITS(64), .DIV_CNT_BITS(7)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .div_init_i      (init),
    .div_busy_o      (busy),
    .div_done_o      (done),
    .div_dividend_i  (dvd),
    .div_divisor_i   (dvs),
    .div_quotient_o  (quot),
    .div_remainder_o (rem),
    .div_zero_o      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t e;
    if (d == '0) begin
      e.q = '1;
      e.r = n;
      e.z = 1'b1;
    end else begin
      e.q = n / d;
      e.r = n % d;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Result checker: pops at each done pulse, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (busy && done) begin
      n_err++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both 1", busy, done);
    end
    if (!rst_n) begin
      hq = '0; hr = '0; hz = 1'b0;
    end
    if (done) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: done pulse with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if ({quot, rem, zero} !== {e.q, e.r, e.z}) begin
          n_err++;
          $display("FAIL result: q=%h r=%h z=%b required q=%h r=%h z=%b", quot, rem, zero, e.q, e.r, e.z);
        end
        hq = e.q; hr = e.r; hz = e.z;
      end
    end else begin
      n_cmp++;
      if ({quot, rem, zero} !== {hq, hr, hz}) begin
        n_err++;
        $display("FAIL hold: q=%h r=%h z=%b required q=%h r=%h z=%b", quot, rem, zero, hq, hr, hz);
      end
    end
  end

  task automatic wait_busy(input int budget);
    int k = 0;
    while (!busy && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (!busy) begin
      n_err++;
      $display("FAIL wait_busy: busy=%0b required 1 within %0d cycles", busy, budget);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL wait_done: done=%0b required 1 within %0d cycles", done, budget);
    end
  endtask

  // One division with latency/busy-length checks; operands scrambled right after the load edge.
  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d);
    int k, nb, l;
    @(negedge clk);
    init = 1'b1; dvd = n; dvs = d;
    sb.push_back(model(n, d));
    @(negedge clk);
    init = 1'b0; l = cyc;
    dvd = {$urandom, $urandom}; dvs = {$urandom, $urandom};
    k = 0; nb = 0;
    while (!done && k < 200) begin
      if (busy) nb++;
      @(negedge clk); k++;
    end
    n_cmp++;
    if (!done || (cyc - l) != W) begin
      n_err++;
      $display("FAIL latency: done=%0b after %0d cycles required 1 after %0d", done, cyc - l, W);
    end
    n_cmp++;
    if (nb != W) begin
      n_err++;
      $display("FAIL busy_len: busy high %0d cycles required %0d", nb, W);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, quot, rem, zero} !== '0) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h z=%b required all 0", busy, done, quot, rem, zero);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_div(64'd100, 64'd7);
    n_cmp++;
    if ({quot, rem, zero} !== {64'd14, 64'd2, 1'b0}) begin
      n_err++;
      $display("FAIL basic_100_7: q=%0d r=%0d z=%b required q=14 r=2 z=0", quot, rem, zero);
    end
  endtask

  task automatic test_edges();
    run_div('1, 64'd1);
    n_cmp++;
    if ({quot, rem} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'd0}) begin
      n_err++;
      $display("FAIL max_div_1: q=%h r=%h required q=ffffffffffffffff r=0", quot, rem);
    end
    run_div(64'd5, 64'd9);
    n_cmp++;
    if ({quot, rem} !== {64'd0, 64'd5}) begin
      n_err++;
      $display("FAIL small_n: q=%0d r=%0d required q=0 r=5", quot, rem);
    end
    run_div(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    n_cmp++;
    if ({quot, rem} !== {64'd1, 64'd0}) begin
      n_err++;
      $display("FAIL msb_equal: q=%0d r=%0d required q=1 r=0", quot, rem);
    end
  endtask

  task automatic test_div_zero();
    run_div(64'h1234, 64'd0);
    n_cmp++;
    if ({quot, rem, zero} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1}) begin
      n_err++;
      $display("FAIL div_zero: q=%h r=%h z=%b required q=ffffffffffffffff r=1234 z=1", quot, rem, zero);
    end
    run_div(64'd10, 64'd3);
    n_cmp++;
    if ({quot, rem, zero} !== {64'd3, 64'd1, 1'b0}) begin
      n_err++;
      $display("FAIL after_zero: q=%0d r=%0d z=%b required q=3 r=1 z=0", quot, rem, zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] n[3], d[3];
    int prev = 0;
    for (int i = 0; i < 3; i++) begin
      n[i] = {$urandom, $urandom};
      d[i] = {32'd0, $urandom} >> $urandom_range(0, 31);
    end
    @(negedge clk);
    init = 1'b1; dvd = n[0]; dvs = d[0];
    sb.push_back(model(n[0], d[0]));
    for (int i = 0; i < 3; i++) begin
      wait_busy(10);
      if (i < 2) begin
        dvd = n[i+1]; dvs = d[i+1];
        sb.push_back(model(n[i+1], d[i+1]));
      end else begin
        init = 1'b0;
        dvd = {$urandom, $urandom}; dvs = {$urandom, $urandom};
      end
      wait_done(200);
      if (i > 0) begin
        n_cmp++;
        if ((cyc - prev) != W + 1) begin
          n_err++;
          $display("FAIL b2b_period: done spacing %0d required %0d", cyc - prev, W + 1);
        end
      end
      prev = cyc;
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_stop: busy=%b required 0 after init dropped", busy);
    end
  endtask

  task automatic test_ignored_init();
    @(negedge clk);
    init = 1'b1; dvd = 64'd100000; dvs = 64'd37;
    sb.push_back(model(64'd100000, 64'd37));
    @(negedge clk);
    init = 1'b0;
    repeat (10) @(negedge clk);
    init = 1'b1; dvd = 64'd5; dvs = 64'd1;
    @(negedge clk);
    init = 1'b0;
    wait_done(200);
    n_cmp++;
    if ({quot, rem} !== {64'd2702, 64'd26}) begin
      n_err++;
      $display("FAIL ignored_init: q=%0d r=%0d required q=2702 r=26", quot, rem);
    end
    repeat (80) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignored_init_idle: pending=%0d busy=%b required 0 and 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    init = 1'b1; dvd = 64'd999; dvs = 64'd4;
    sb.push_back(model(64'd999, 64'd4));
    @(negedge clk);
    init = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, quot, rem, zero} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h z=%b required all 0", busy, done, quot, rem, zero);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL reset_no_done: %0d done pulses required 0", seen);
    end
    run_div(64'd81, 64'd9);
    n_cmp++;
    if ({quot, rem, zero} !== {64'd9, 64'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_restart: q=%0d r=%0d z=%b required q=9 r=0 z=0", quot, rem, zero);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] n, d;
    for (int i = 0; i < 1000; i++) begin
      n = {$urandom, $urandom};
      case (i % 4)
        0:       d = {$urandom, $urandom};
        1:       d = 64'($urandom_range(1, 255));
        2:       d = {$urandom, $urandom} >> $urandom_range(0, 63);
        default: d = 64'($urandom_range(1, 65535));
      endcase
      if (i % 97 == 0) d = '0;
      run_div(n, d);
    end
  endtask

  initial begin
    rst_n = 1'b1; init = 1'b0; dvd = '0; dvs = '0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_back_to_back();
    test_ignored_init();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
